// File: rtl/alu_issue_ctrl.sv
// Decode/issue front end for the MiniCPU: accepts instructions, reads the 8-entry register
// file, drives the external ALU, writes back, and returns each result on a response port.
module alu_issue_ctrl #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ins_valid,
  output logic         ins_ready,
  input  logic [15:0]  ins_data,
  output logic [N-1:0] alu_A,
  output logic [N-1:0] alu_B,
  output logic [3:0]   alu_opcode,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic [2:0]   res_rd,
  output logic [3:0]   flags_q,
  output logic         ill_op,
  output logic         halted
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_LAST_ALU = 4'hA;
  localparam logic [3:0] OP_HALT     = 4'hE;
  localparam logic [3:0] OP_LOADI    = 4'hF;

  state_t       state_q, state_d;
  logic [N-1:0] regs_q [8];
  logic [N-1:0] regs_d [8];
  logic [3:0]   op_q, op_d;
  logic [2:0]   rd_q, rd_d;
  logic [8:0]   imm_q, imm_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_op_q, alu_op_d;
  logic [N-1:0] res_data_q, res_data_d;
  logic [2:0]   res_rd_q, res_rd_d;
  logic [3:0]   flags_d;
  logic         ill_op_q, ill_op_d;
  logic         halted_q, halted_d;

  logic [3:0]   ins_op;
  logic [2:0]   ins_rs1, ins_rs2;
  logic         ins_ill;
  logic         accept;

  assign ins_op  = ins_data[15:12];
  assign ins_rs1 = ins_data[8:6];
  assign ins_rs2 = ins_data[5:3];
  assign ins_ill = (ins_op > OP_LAST_ALU) && (ins_op < OP_HALT);
  assign accept  = ins_valid && ins_ready;

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      flags_q    <= '0;
      ill_op_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      flags_q    <= flags_d;
      ill_op_q   <= ill_op_d;
      halted_q   <= halted_d;
    end
  end

  // Illegal opcodes are consumed in IDLE without leaving it
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !ins_ill) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ins_ready  = (state_q == IDLE) && !halted_q;
    res_valid  = (state_q == RESP);
    alu_A      = alu_a_q;
    alu_B      = alu_b_q;
    alu_opcode = alu_op_q;
    res_data   = res_data_q;
    res_rd     = res_rd_q;
    ill_op     = ill_op_q;
    halted     = halted_q;
  end

  always_comb begin
    regs_d     = regs_q;
    op_d       = op_q;
    rd_d       = rd_q;
    imm_d      = imm_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    flags_d    = flags_q;
    ill_op_d   = 1'b0;
    halted_d   = halted_q;

    if (accept) begin
      if (ins_ill) begin
        ill_op_d = 1'b1;
      end else begin
        op_d     = ins_op;
        rd_d     = ins_data[11:9];
        imm_d    = ins_data[8:0];
        alu_a_d  = (ins_rs1 == 3'd0) ? '0 : regs_q[ins_rs1];
        alu_b_d  = (ins_rs2 == 3'd0) ? '0 : regs_q[ins_rs2];
        alu_op_d = ins_op;
      end
    end

    // R0 is never written, so it keeps reading zero
    if (state_q == EXEC) begin
      res_rd_d = rd_q;
      case (op_q)
        OP_LOADI: begin
          res_data_d = N'(imm_q);
          if (rd_q != 3'd0) regs_d[rd_q] = N'(imm_q);
        end
        OP_HALT: begin
          res_data_d = '0;
          halted_d   = 1'b1;
        end
        default: begin
          res_data_d = alu_result;
          flags_d    = alu_flags;
          if (rd_q != 3'd0) regs_d[rd_q] = alu_result;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop;
// table-driven instruction stream plus sequences for back-pressure, illegal op, HALT and reset.
module tb_alu_issue_ctrl;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ins_valid;
  logic         ins_ready;
  logic [15:0]  ins_data;
  logic [N-1:0] alu_A, alu_B;
  logic [3:0]   alu_opcode;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic [2:0]   res_rd;
  logic [3:0]   flags_q;
  logic         ill_op;
  logic         halted;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .flags_q(flags_q), .ill_op(ill_op), .halted(halted)
  );

  // Behavioural ALU: C is carry-out for ADD and borrow for SUB
  logic [N:0]   sum;
  logic [N-1:0] diff;
  logic         c_f, v_f;
  always_comb begin
    sum        = {1'b0, alu_A} + {1'b0, alu_B};
    diff       = alu_A - alu_B;
    alu_result = '0;
    c_f        = 1'b0;
    v_f        = 1'b0;
    case (alu_opcode)
      4'd0: begin
        alu_result = sum[N-1:0];
        c_f = sum[N];
        v_f = (alu_A[N-1] == alu_B[N-1]) && (sum[N-1] != alu_A[N-1]);
      end
      4'd1: begin
        alu_result = diff;
        c_f = alu_A < alu_B;
        v_f = (alu_A[N-1] != alu_B[N-1]) && (diff[N-1] != alu_A[N-1]);
      end
      4'd2:  alu_result = alu_A & alu_B;
      4'd3:  alu_result = alu_A | alu_B;
      4'd4:  alu_result = alu_A ^ alu_B;
      4'd5:  alu_result = ~alu_A;
      4'd6:  alu_result = alu_A << alu_B[3:0];
      4'd7:  alu_result = alu_A >> alu_B[3:0];
      4'd8:  alu_result = alu_A * alu_B;
      4'd9:  alu_result = (alu_B == '0) ? '1 : alu_A / alu_B;
      4'd10: alu_result = $signed(alu_A) >>> alu_B[3:0];
      default: alu_result = '0;
    endcase
    alu_flags = {alu_result == '0, c_f, alu_result[N-1], v_f};
  end

  typedef struct {
    logic [15:0] ins;
    logic [15:0] data;
    logic [2:0]  rd;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [17];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  function automatic logic [15:0] li(input logic [2:0] rd, input logic [8:0] imm);
    return {4'hF, rd, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge with res_ready=1; returns one cycle after the response
  task automatic run(input string nm, input logic [15:0] ins, input logic [15:0] ed,
                     input logic [2:0] erd, input logic [3:0] ef);
    int n;
    ins_valid = 1'b1;
    ins_data  = ins;
    n = 0;
    while (!ins_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, " accept_wait"}, n, 0);
    @(negedge clk);
    ins_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk({nm, " latency"}, n, 1);
    chk({nm, " res_data"}, res_data, ed);
    chk({nm, " res_rd"}, res_rd, erd);
    chk({nm, " flags"}, flags_q, ef);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{li(3'd1, 9'd10),             16'h000A, 3'd1, 4'b0000};
    vecs[1]  = '{li(3'd2, 9'd5),              16'h0005, 3'd2, 4'b0000};
    vecs[2]  = '{rr(4'd0, 3'd3, 3'd1, 3'd2),  16'h000F, 3'd3, 4'b0000};
    vecs[3]  = '{rr(4'd1, 3'd4, 3'd1, 3'd1),  16'h0000, 3'd4, 4'b1000};
    vecs[4]  = '{li(3'd4, 9'd7),              16'h0007, 3'd4, 4'b1000};
    vecs[5]  = '{rr(4'd5, 3'd6, 3'd0, 3'd0),  16'hFFFF, 3'd6, 4'b0010};
    vecs[6]  = '{li(3'd7, 9'd1),              16'h0001, 3'd7, 4'b0010};
    vecs[7]  = '{rr(4'd0, 3'd5, 3'd6, 3'd7),  16'h0000, 3'd5, 4'b1100};
    vecs[8]  = '{rr(4'd8, 3'd3, 3'd1, 3'd2),  16'h0032, 3'd3, 4'b0000};
    vecs[9]  = '{rr(4'd6, 3'd4, 3'd4, 3'd7),  16'h000E, 3'd4, 4'b0000};
    vecs[10] = '{rr(4'd4, 3'd2, 3'd6, 3'd1),  16'hFFF5, 3'd2, 4'b0010};
    vecs[11] = '{rr(4'd10, 3'd5, 3'd6, 3'd7), 16'hFFFF, 3'd5, 4'b0010};
    vecs[12] = '{rr(4'd1, 3'd0, 3'd2, 3'd1),  16'hFFEB, 3'd0, 4'b0010};
    vecs[13] = '{rr(4'd3, 3'd5, 3'd0, 3'd0),  16'h0000, 3'd5, 4'b1000};
    vecs[14] = '{rr(4'd9, 3'd6, 3'd3, 3'd1),  16'h0005, 3'd6, 4'b0000};
    vecs[15] = '{rr(4'd7, 3'd7, 3'd2, 3'd7),  16'h7FFA, 3'd7, 4'b0000};
    vecs[16] = '{rr(4'd2, 3'd3, 3'd2, 3'd6),  16'h0005, 3'd3, 4'b0000};

    rst = 1'b1; ins_valid = 1'b0; ins_data = '0; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst alu_A", alu_A, 0);
    chk("rst alu_B", alu_B, 0);
    chk("rst alu_opcode", alu_opcode, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst res_data", res_data, 0);
    chk("rst flags", flags_q, 0);
    chk("rst halted", halted, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ins_ready", ins_ready, 1);

    for (int i = 0; i < 17; i++)
      run($sformatf("vec%0d", i), vecs[i].ins, vecs[i].data, vecs[i].rd, vecs[i].flags);

    // Back-pressure: ADD r1,r1,r4 = 10 + 14, response held for 5 cycles
    res_ready = 1'b0;
    chk("bp ins_ready", ins_ready, 1);
    ins_valid = 1'b1;
    ins_data  = rr(4'd0, 3'd1, 3'd1, 3'd4);
    @(negedge clk);
    ins_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d res_valid", k), res_valid, 1);
      chk($sformatf("bp%0d res_data", k), res_data, 16'h0018);
      chk($sformatf("bp%0d ins_ready", k), ins_ready, 0);
      @(negedge clk);
    end
    chk("bp res_rd", res_rd, 1);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp release res_valid", res_valid, 0);
    chk("bp release ins_ready", ins_ready, 1);

    // Writes to R0 are reported but dropped
    run("ld r0", li(3'd0, 9'h055), 16'h0055, 3'd0, 4'b0000);
    run("or r2,r0,r0", rr(4'd3, 3'd2, 3'd0, 3'd0), 16'h0000, 3'd2, 4'b1000);

    // Illegal opcode targeting r1
    ins_valid = 1'b1;
    ins_data  = {4'hC, 3'd1, 3'd1, 3'd1, 3'b000};
    @(negedge clk);
    ins_valid = 1'b0;
    chk("ill pulse", ill_op, 1);
    chk("ill no resp", res_valid, 0);
    @(negedge clk);
    chk("ill pulse end", ill_op, 0);
    chk("ill no resp2", res_valid, 0);
    chk("ill ins_ready", ins_ready, 1);
    chk("ill flags", flags_q, 4'b1000);
    run("add r3,r1,r0", rr(4'd0, 3'd3, 3'd1, 3'd0), 16'h0018, 3'd3, 4'b0000);

    // HALT still responds, then blocks further instructions
    run("halt", 16'hE000, 16'h0000, 3'd0, 4'b0000);
    chk("halt halted", halted, 1);
    chk("halt ins_ready", ins_ready, 0);
    ins_valid = 1'b1;
    ins_data  = li(3'd1, 9'd3);
    repeat (4) @(negedge clk);
    chk("halt no accept", res_valid, 0);
    chk("halt still ready0", ins_ready, 0);
    ins_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("unhalt halted", halted, 0);
    chk("unhalt ins_ready", ins_ready, 1);

    // Reset while an ADD is in EXEC
    run("ld r1", li(3'd1, 9'd10), 16'h000A, 3'd1, 4'b0000);
    run("ld r2", li(3'd2, 9'd5), 16'h0005, 3'd2, 4'b0000);
    ins_valid = 1'b1;
    ins_data  = rr(4'd0, 3'd3, 3'd1, 3'd2);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("exec alu_A", alu_A, 16'h000A);
    chk("exec alu_B", alu_B, 16'h0005);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst alu_A", alu_A, 0);
    chk("mid rst alu_B", alu_B, 0);
    chk("mid rst alu_opcode", alu_opcode, 0);
    chk("mid rst res_valid", res_valid, 0);
    chk("mid rst res_data", res_data, 0);
    chk("mid rst res_rd", res_rd, 0);
    chk("mid rst flags", flags_q, 0);
    chk("mid rst ill_op", ill_op, 0);
    chk("mid rst halted", halted, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post rst res_valid", res_valid, 0);
    run("or r4,r3,r2", rr(4'd3, 3'd4, 3'd3, 3'd2), 16'h0000, 3'd4, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
